// File: rtl/sample_pkg.sv
// Shared sample type, gate FSM states and gain helpers for the noise gate.
package sample_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int GAIN_UNITY = 256;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [2:0] {
        CLOSED,
        ATTACK,
        OPEN,
        HOLD,
        RELEASE
    } gate_state_t;

    // Gain is 9-bit 0..256; both helpers clamp to that range.
    function automatic logic [8:0] gain_add(input logic [8:0] g, input int step);
        int s;
        s = int'(g) + step;
        return (s >= GAIN_UNITY) ? 9'(GAIN_UNITY) : 9'(s);
    endfunction

    function automatic logic [8:0] gain_sub(input logic [8:0] g, input int step);
        int s;
        s = int'(g) - step;
        return (s <= 0) ? 9'd0 : 9'(s);
    endfunction

endpackage

// File: rtl/env_follower.sv
// Peak envelope follower: saturating magnitude and per-sample exponential decay.
module env_follower
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH  = SAMPLE_W,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_vld,
    output logic        [DATA_WIDTH-2:0] env,
    output logic                         env_vld
);

    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH-2:0] mag;
    logic [DATA_WIDTH-2:0] decayed;

    // The most negative code has no positive twin, so it pins to full scale.
    always_comb begin
        mag = in_data[DATA_WIDTH-2:0];
        if (in_data == MOST_NEG) begin
            mag = '1;
        end else if (in_data[DATA_WIDTH-1]) begin
            mag = (DATA_WIDTH-1)'(-in_data);
        end
    end

    assign decayed = env - (env >> DECAY_SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            env     <= '0;
            env_vld <= 1'b0;
        end else begin
            env_vld <= in_vld;
            if (in_vld) begin
                env <= (mag > decayed) ? mag : decayed;
            end
        end
    end

endmodule

// File: rtl/noise_gate.sv
// Noise gate: envelope-driven gain FSM scaling each sample, two-cycle latency.
// Handshake: in_vld and out_vld are single-cycle strobes with no backpressure; every in_vld yields exactly one out_vld two clocks later.
module noise_gate
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH   = SAMPLE_W,
    parameter int DECAY_SHIFT  = 4,
    parameter int HOLD_SAMPLES = 16,
    parameter int ATTACK_STEP  = 32,
    parameter int RELEASE_STEP = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic                         in_vld,
    input  logic        [DATA_WIDTH-2:0] thresh_open,
    input  logic        [DATA_WIDTH-2:0] thresh_close,
    input  logic                         bypass,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_vld,
    output logic                         gate_open,
    output gate_state_t                  dbg_state,
    output logic        [8:0]            dbg_gain,
    output logic        [DATA_WIDTH-2:0] dbg_env
);

    localparam int CW = $clog2(HOLD_SAMPLES + 2);
    localparam int PW = DATA_WIDTH + 9;

    logic [DATA_WIDTH-2:0] env;
    logic                  env_vld;

    env_follower #(
        .DATA_WIDTH (DATA_WIDTH),
        .DECAY_SHIFT(DECAY_SHIFT)
    ) u_env (
        .clk    (clk),
        .rst    (rst),
        .in_data(in_data),
        .in_vld (in_vld),
        .env    (env),
        .env_vld(env_vld)
    );

    // Sample and controls travel alongside the envelope so a control change
    // only affects samples accepted after it.
    logic signed [DATA_WIDTH-1:0] data1;
    logic                         bypass1;
    logic        [DATA_WIDTH-2:0] topen1;
    logic        [DATA_WIDTH-2:0] tclose1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data1   <= '0;
            bypass1 <= 1'b0;
            topen1  <= '0;
            tclose1 <= '0;
        end else if (in_vld) begin
            data1   <= in_data;
            bypass1 <= bypass;
            topen1  <= thresh_open;
            tclose1 <= thresh_close;
        end
    end

    gate_state_t    state;
    logic [8:0]     gain;
    logic [CW-1:0]  hold_cnt;

    logic [8:0]           gain_up;
    logic [8:0]           gain_dn;
    logic                 up_full;
    logic                 dn_zero;
    logic                 loud;
    logic signed [PW-1:0] data_x;
    logic signed [PW-1:0] gain_x;
    logic signed [PW-1:0] prod;

    assign gain_up = gain_add(gain, ATTACK_STEP);
    assign gain_dn = gain_sub(gain, RELEASE_STEP);
    assign up_full = (gain_up == 9'(GAIN_UNITY));
    assign dn_zero = (gain_dn == 9'd0);
    assign loud    = (env >= topen1);

    // Product uses the gain before this sample's FSM update.
    assign data_x = PW'(data1);
    assign gain_x = PW'(gain);
    assign prod   = data_x * gain_x;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= CLOSED;
            gain      <= '0;
            hold_cnt  <= '0;
            out_data  <= '0;
            out_vld   <= 1'b0;
            gate_open <= 1'b0;
        end else begin
            out_vld <= env_vld;
            if (env_vld) begin
                out_data <= bypass1 ? data1 : DATA_WIDTH'(prod >>> 8);
                case (state)
                    CLOSED: begin
                        if (loud) begin
                            gain      <= gain_up;
                            state     <= up_full ? OPEN : ATTACK;
                            gate_open <= 1'b1;
                        end
                    end
                    ATTACK: begin
                        gain <= gain_up;
                        if (up_full) state <= OPEN;
                    end
                    OPEN: begin
                        gain <= 9'(GAIN_UNITY);
                        if (env < tclose1) begin
                            state    <= HOLD;
                            hold_cnt <= CW'(HOLD_SAMPLES);
                        end
                    end
                    HOLD: begin
                        if (loud) begin
                            state <= OPEN;
                        end else if (hold_cnt > CW'(1)) begin
                            hold_cnt <= hold_cnt - CW'(1);
                        end else begin
                            hold_cnt  <= '0;
                            gain      <= gain_dn;
                            gate_open <= 1'b0;
                            state     <= dn_zero ? CLOSED : RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (loud) begin
                            gain      <= gain_up;
                            state     <= up_full ? OPEN : ATTACK;
                            gate_open <= 1'b1;
                        end else begin
                            gain <= gain_dn;
                            if (dn_zero) state <= CLOSED;
                        end
                    end
                    default: begin
                        state     <= CLOSED;
                        gain      <= '0;
                        gate_open <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dbg_state = state;
    assign dbg_gain  = gain;
    assign dbg_env   = env;

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate with a sample-level reference model and a per-cycle compare.
module tb_noise_gate;
    import sample_pkg::*;

    localparam int W = 24;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [W-1:0] in_data = '0;
    logic                in_vld  = 1'b0;
    logic        [W-2:0] thresh_open  = 23'h010000;
    logic        [W-2:0] thresh_close = 23'h008000;
    logic                bypass = 1'b0;
    logic signed [W-1:0] out_data;
    logic                out_vld;
    logic                gate_open;
    gate_state_t         dbg_state;
    logic        [8:0]   dbg_gain;
    logic        [W-2:0] dbg_env;

    noise_gate dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_vld      (in_vld),
        .thresh_open (thresh_open),
        .thresh_close(thresh_close),
        .bypass      (bypass),
        .out_data    (out_data),
        .out_vld     (out_vld),
        .gate_open   (gate_open),
        .dbg_state   (dbg_state),
        .dbg_gain    (dbg_gain),
        .dbg_env     (dbg_env)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // reference model: one call per accepted sample
    longint menv;
    int     mgain;
    int     mhold;
    string  mstate;

    logic [W-1:0] exp_q[$];
    int           due_q[$];
    logic         gate_q[$];
    logic         exp_gate = 1'b0;
    logic [W-1:0] got_q[$];

    function automatic void model_reset();
        menv   = 0;
        mgain  = 0;
        mhold  = 0;
        mstate = "closed";
    endfunction

    function automatic int clamp_gain(input int g);
        if (g > 256) return 256;
        if (g < 0) return 0;
        return g;
    endfunction

    task automatic model_push(input logic signed [W-1:0] d);
        longint x, a, dec, p, res, topen, tclose;
        x = longint'(d);
        a = (x < 0) ? -x : x;
        if (a > 8388607) a = 8388607;
        dec  = menv - (menv >>> 4);
        menv = (a > dec) ? a : dec;
        topen  = longint'(thresh_open);
        tclose = longint'(thresh_close);
        if (bypass) begin
            res = x;
        end else begin
            p   = x * mgain;
            res = p / 256;
            if (p < 0 && (p % 256) != 0) res = res - 1;
        end
        if (mstate == "closed" || mstate == "release") begin
            if (menv >= topen) begin
                mgain  = clamp_gain(mgain + 32);
                mstate = (mgain == 256) ? "open" : "attack";
            end else if (mstate == "release") begin
                mgain = clamp_gain(mgain - 8);
                if (mgain == 0) mstate = "closed";
            end
        end else if (mstate == "attack") begin
            mgain = clamp_gain(mgain + 32);
            if (mgain == 256) mstate = "open";
        end else if (mstate == "open") begin
            if (menv < tclose) begin
                mstate = "hold";
                mhold  = 16;
            end
        end else begin
            if (menv >= topen) begin
                mstate = "open";
            end else begin
                mhold--;
                if (mhold == 0) begin
                    mgain  = clamp_gain(mgain - 8);
                    mstate = (mgain == 0) ? "closed" : "release";
                end
            end
        end
        exp_q.push_back(W'(res));
        due_q.push_back(cyc + 2);
        gate_q.push_back(mstate == "attack" || mstate == "open" || mstate == "hold");
    endtask

    // driver tasks
    task automatic send(input logic signed [W-1:0] d);
        @(posedge clk);
        #1;
        in_data = d;
        in_vld  = 1'b1;
        model_push(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_vld  = 1'b0;
            in_data = '0;
        end
    endtask

    // scoreboard compare, every cycle
    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            check("out_vld", W'(out_vld), 24'd1);
            check("out_data", out_data, exp_q[0]);
            exp_gate = gate_q[0];
            got_q.push_back(out_data);
            void'(exp_q.pop_front());
            void'(due_q.pop_front());
            void'(gate_q.pop_front());
        end else begin
            check("out_vld_idle", W'(out_vld), 24'd0);
        end
        check("gate_open", W'(gate_open), W'(exp_gate));
    end

    logic [W-1:0] attack_exp [10] = '{24'h000000, 24'h020000, 24'h040000, 24'h060000,
                                      24'h080000, 24'h0A0000, 24'h0C0000, 24'h0E0000,
                                      24'h100000, 24'h100000};
    logic [W-1:0] retrig_exp [5]  = '{24'h080000, 24'h0A0000, 24'h0C0000, 24'h0E0000, 24'h100000};
    logic [W-1:0] sent_q[$];

    initial begin
        longint e;
        int c, k, guard;
        logic signed [W-1:0] d;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_vld", W'(out_vld), 24'd0);
        check("rst_out_data", out_data, 24'd0);
        check("rst_gate", W'(gate_open), 24'd0);
        check("rst_state", W'(dbg_state), W'(CLOSED));
        check("rst_gain", W'(dbg_gain), 24'd0);
        check("rst_env", W'(dbg_env), 24'd0);
        @(negedge clk);
        rst = 1'b1;

        // attack ramp
        got_q.delete();
        for (int i = 0; i < 10; i++) send(24'h100000);
        idle(3);
        check("attack_count", W'(got_q.size()), 24'd10);
        if (got_q.size() == 10)
            for (int i = 0; i < 10; i++) check("attack_out", got_q[i], attack_exp[i]);
        check("attack_state", W'(dbg_state), W'(OPEN));

        // hold then release with a small probe tone so out_data shows the gain
        got_q.delete();
        for (int i = 0; i < 120; i++) send(24'h000100);
        idle(3);
        e = 64'h100000;
        c = -1;
        for (int i = 0; i < 120 && c < 0; i++) begin
            e = e - (e >>> 4);
            if (e < 256) e = 256;
            if (e < 64'h8000) c = i;
        end
        k = -1;
        for (int i = 0; i < got_q.size() && k < 0; i++)
            if (got_q[i] != 24'h000100) k = i;
        check("hold_len", W'(k), W'(c + 17));
        if (k >= 0 && k + 32 < got_q.size())
            for (int j = 0; j < 32; j++) check("release_ramp", got_q[k + j], W'(248 - 8 * j));
        check("closed_state", W'(dbg_state), W'(CLOSED));
        check("closed_gain", W'(dbg_gain), 24'd0);

        // retrigger from release at half gain
        for (int i = 0; i < 10; i++) send(24'h100000);
        guard = 0;
        while (!(mstate == "release" && mgain == 128) && guard < 300) begin
            send(24'h000100);
            guard++;
        end
        check("reach_release", W'(guard < 300), 24'd1);
        idle(3);
        check("release_gain", W'(dbg_gain), 24'd128);
        got_q.delete();
        for (int i = 0; i < 5; i++) send(24'h100000);
        idle(3);
        if (got_q.size() == 5)
            for (int i = 0; i < 5; i++) check("retrig_out", got_q[i], retrig_exp[i]);
        else
            check("retrig_count", W'(got_q.size()), 24'd5);
        check("retrig_state", W'(dbg_state), W'(OPEN));

        // full-scale extremes at unity gain
        got_q.delete();
        send(24'h800000);
        idle(3);
        check("neg_full_env", W'(dbg_env), 24'h7FFFFF);
        send(24'h7FFFFF);
        idle(3);
        if (got_q.size() == 2) begin
            check("neg_full_out", got_q[0], 24'h800000);
            check("pos_full_out", got_q[1], 24'h7FFFFF);
        end else begin
            check("extreme_count", W'(got_q.size()), 24'd2);
        end

        // bypass at full throughput
        bypass = 1'b1;
        got_q.delete();
        sent_q.delete();
        for (int i = 0; i < 100; i++) begin
            d = W'($urandom);
            sent_q.push_back(d);
            send(d);
        end
        idle(3);
        check("bypass_count", W'(got_q.size()), 24'd100);
        if (got_q.size() == 100)
            for (int i = 0; i < 100; i++) check("bypass_data", got_q[i], sent_q[i]);

        // mixed traffic with control changes between samples
        for (int i = 0; i < 80; i++) begin
            if (i % 10 == 0) begin
                bypass       = 1'($urandom_range(0, 1));
                thresh_open  = 23'($urandom_range(32'h1000, 32'h200000));
                thresh_close = thresh_open >> $urandom_range(0, 3);
            end
            d = W'($urandom);
            d = d >>> $urandom_range(0, 12);
            send(d);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);

        // asynchronous reset in the middle of a stream
        bypass       = 1'b0;
        thresh_open  = 23'h010000;
        thresh_close = 23'h008000;
        for (int i = 0; i < 12; i++) send(24'h100000);
        @(negedge clk);
        #2;
        rst    = 1'b0;
        in_vld = 1'b0;
        exp_q.delete();
        due_q.delete();
        gate_q.delete();
        exp_gate = 1'b0;
        model_reset();
        #1;
        check("async_out_vld", W'(out_vld), 24'd0);
        check("async_out_data", out_data, 24'd0);
        check("async_gate", W'(gate_open), 24'd0);
        check("async_state", W'(dbg_state), W'(CLOSED));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        got_q.delete();
        send(24'h100000);
        send(24'h100000);
        idle(4);
        check("post_rst_count", W'(got_q.size()), 24'd2);
        if (got_q.size() == 2) begin
            check("post_rst_first", got_q[0], 24'h000000);
            check("post_rst_second", got_q[1], 24'h020000);
        end

        idle(3);
        check("drain", W'(exp_q.size()), 24'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noise_gate.md
NOISE_GATE -- requirements
Module: noise_gate

Interface
REQ-001 Parameter DATA_WIDTH, default 24, sample width; matches sample_pkg::sample_t.
REQ-002 Parameter DECAY_SHIFT, default 4, envelope decay per sample: env - (env >> DECAY_SHIFT).
REQ-003 Parameter HOLD_SAMPLES, default 16, valid samples spent in HOLD before RELEASE.
REQ-004 Parameter ATTACK_STEP, default 32, gain increment per valid sample in ATTACK.
REQ-005 Parameter RELEASE_STEP, default 8, gain decrement per valid sample in RELEASE.
REQ-006 clk  in  1  single system clock; every register is clocked on its rising edge.
REQ-007 rst  in  1  reset; asynchronous assert, active-low (rst = 0 resets).
REQ-008 in_data  in  sample_t  signed sample from the i2s core rx_data.
REQ-009 in_vld  in  1  one-cycle strobe qualifying in_data; from i2s rx_vld.
REQ-010 thresh_open  in  DATA_WIDTH-1  unsigned envelope level that opens the gate.
REQ-011 thresh_close  in  DATA_WIDTH-1  unsigned level that closes the gate; thresh_close <= thresh_open.
REQ-012 bypass  in  1  1 = pass samples unmodified; the FSM keeps running.
REQ-013 out_data  out  sample_t  gated sample, drives i2s tx_data.
REQ-014 out_vld  out  1  one-cycle strobe qualifying out_data, drives i2s tx_vld.
REQ-015 gate_open  out  1  high in states ATTACK, OPEN and HOLD.

Function
REQ-016 Latency: out_vld pulses exactly 2 clk after each in_vld; throughput is one sample per clk, with back-to-back in_vld supported.
REQ-017 abs = |in_data|; -2^(DATA_WIDTH-1) saturates to 2^(DATA_WIDTH-1)-1.
REQ-018 Per valid sample: env <= max(abs, env - (env >> DECAY_SHIFT)); env is unsigned, DATA_WIDTH-1 bits.
REQ-019 Gain is a 9-bit unsigned value in the range 0..256, where 256 is unity; increments saturate at 256 and decrements floor at 0.
REQ-020 out_data = (in_data * g) >>> 8, an arithmetic-shift floor, where g is the gain held before this sample's FSM update; no overflow is possible.
REQ-021 In bypass, out_data = in_data with unchanged latency.
REQ-022 The FSM advances only on valid samples and uses the updated env from REQ-018.
REQ-023 CLOSED: gain 0; env >= thresh_open -> ATTACK.
REQ-024 ATTACK: gain += ATTACK_STEP; when the result reaches 256 -> OPEN.
REQ-025 OPEN: gain 256; env < thresh_close -> HOLD and the hold counter loads HOLD_SAMPLES.
REQ-026 HOLD: gain 256; env >= thresh_open -> OPEN; otherwise the counter decrements, and on reaching 0 -> RELEASE.
REQ-027 RELEASE: gain -= RELEASE_STEP; env >= thresh_open -> ATTACK from the current gain (retrigger has priority); when gain reaches 0 -> CLOSED.
REQ-028 A threshold or bypass change takes effect from the next valid sample; the values are sampled on the in_vld cycle.
REQ-029 If in_vld arrives while a previous sample is in flight, the pipeline processes both in order without stalls or drops.

Reset
REQ-030 While rst = 0: state CLOSED, gain 0, env 0, hold counter 0, pipeline valid bits 0, out_data 0, out_vld 0, gate_open 0.
REQ-031 A reset asserted mid-stream discards in-flight samples; no out_vld is produced for samples accepted before the reset.
REQ-032 The first valid sample after rst deassertion is processed normally; no dead cycles are required.

Structure
REQ-033 sample_pkg owns sample_t and the new gate_state_t enum (CLOSED, ATTACK, OPEN, HOLD, RELEASE) and GAIN_UNITY = 256.
REQ-034 The module contains one sub-module, env_follower, which computes abs and env (REQ-017/018) and outputs env alongside a valid strobe.

Verification
REQ-035 Reset: drop rst mid-stream -> out_vld and out_data go to 0 and gate_open to 0 without waiting for a clock edge; no stale out_vld appears after release.
REQ-036 Attack: with thresh_open 0x010000 and thresh_close 0x008000, feed constant 0x100000 -> outputs 0x000000, 0x020000, 0x040000, ... ; the 9th output onward is 0x100000 (state OPEN).
REQ-037 Hold/release: from OPEN, feed zeros -> once env < 0x008000, 16 more outputs at unity gain; gain then falls by 8 per sample, reaching 0 after 32 samples -> CLOSED.
REQ-038 Retrigger: in RELEASE at gain 128, feed 0x100000 -> ATTACK; gain is 160, 192, 224, 256 -> OPEN on the 4th sample.
REQ-039 Extremes: in OPEN, feed -0x800000 -> out_data -0x800000 and env 0x7FFFFF.
REQ-040 Bypass and throughput: set bypass = 1 and assert in_vld every clk for 100 cycles -> out_vld on every clk from cycle 2, with out_data equal to in_data delayed by 2 clk.
